lfsr_prng_gen: RTL and testbench

Parametrised maximal-length LFSR pseudo-random generator. It is the successor to the fixed 8-bit shift generator. It adds configurable width and taps, Galois or Fibonacci structure, run-time seed loading with all-zero lockup protection, a valid/ready output handshake, and period-completion detection. It feeds test-pattern, scrambler and dither consumers that may stall.

---
 rtl/lfsr_pkg.sv | 74 +++++++
 rtl/lfsr_prng_gen_step.sv | 28 ++
 rtl/lfsr_prng_gen.sv | 108 ++++++++++
 tb/tb_lfsr_prng_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: structure selectors and
// maximal-length tap masks for widths 4..32.
package lfsr_pkg;

  localparam bit MODE_FIBONACCI = 1'b0;
  localparam bit MODE_GALOIS    = 1'b1;

  localparam logic [3:0]  TAPS_4  = 4'hC;
  localparam logic [4:0]  TAPS_5  = 5'h14;
  localparam logic [5:0]  TAPS_6  = 6'h30;
  localparam logic [6:0]  TAPS_7  = 7'h60;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [8:0]  TAPS_9  = 9'h110;
  localparam logic [9:0]  TAPS_10 = 10'h240;
  localparam logic [10:0] TAPS_11 = 11'h500;
  localparam logic [11:0] TAPS_12 = 12'hE08;
  localparam logic [12:0] TAPS_13 = 13'h1C80;
  localparam logic [13:0] TAPS_14 = 14'h3802;
  localparam logic [14:0] TAPS_15 = 15'h6000;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [16:0] TAPS_17 = 17'h12000;
  localparam logic [17:0] TAPS_18 = 18'h20400;
  localparam logic [18:0] TAPS_19 = 19'h72000;
  localparam logic [19:0] TAPS_20 = 20'h90000;
  localparam logic [20:0] TAPS_21 = 21'h140000;
  localparam logic [21:0] TAPS_22 = 22'h300000;
  localparam logic [22:0] TAPS_23 = 23'h420000;
  localparam logic [23:0] TAPS_24 = 24'hE10000;
  localparam logic [24:0] TAPS_25 = 25'h1200000;
  localparam logic [25:0] TAPS_26 = 26'h2000023;
  localparam logic [26:0] TAPS_27 = 27'h4000013;
  localparam logic [27:0] TAPS_28 = 28'h9000000;
  localparam logic [28:0] TAPS_29 = 29'h14000000;
  localparam logic [29:0] TAPS_30 = 30'h20000029;
  localparam logic [30:0] TAPS_31 = 31'h48000000;
  localparam logic [31:0] TAPS_32 = 32'h80200003;

  // Zero-extended default mask for a width; zero means the width is unsupported.
  function automatic logic [31:0] default_taps(input int unsigned width);
    case (width)
      4:       return 32'(TAPS_4);
      5:       return 32'(TAPS_5);
      6:       return 32'(TAPS_6);
      7:       return 32'(TAPS_7);
      8:       return 32'(TAPS_8);
      9:       return 32'(TAPS_9);
      10:      return 32'(TAPS_10);
      11:      return 32'(TAPS_11);
      12:      return 32'(TAPS_12);
      13:      return 32'(TAPS_13);
      14:      return 32'(TAPS_14);
      15:      return 32'(TAPS_15);
      16:      return 32'(TAPS_16);
      17:      return 32'(TAPS_17);
      18:      return 32'(TAPS_18);
      19:      return 32'(TAPS_19);
      20:      return 32'(TAPS_20);
      21:      return 32'(TAPS_21);
      22:      return 32'(TAPS_22);
      23:      return 32'(TAPS_23);
      24:      return 32'(TAPS_24);
      25:      return 32'(TAPS_25);
      26:      return 32'(TAPS_26);
      27:      return 32'(TAPS_27);
      28:      return 32'(TAPS_28);
      29:      return 32'(TAPS_29);
      30:      return 32'(TAPS_30);
      31:      return 32'(TAPS_31);
      32:      return TAPS_32;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_prng_gen_step.sv
// Purely combinational single LFSR step, Galois right-shift or
// Fibonacci left-shift depending on GALOIS.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = TAPS_8,
  parameter bit               GALOIS = MODE_GALOIS
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  // One shift of the register with tap feedback.
  always_comb begin
    next_state = state;
    if (GALOIS == MODE_GALOIS) begin
      if (state[0]) begin
        next_state = {1'b0, state[WIDTH-1:1]} ^ TAPS;
      end else begin
        next_state = {1'b0, state[WIDTH-1:1]};
      end
    end else begin
      next_state = {state[WIDTH-2:0], ^(state & TAPS)};
    end
  end

endmodule

// File: rtl/lfsr_prng_gen.sv
// Maximal-length LFSR generator with seed loading, zero-lockup recovery,
// valid/ready output handshake and period-completion detection.
module lfsr_prng_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] TAPS   = TAPS_8,
  parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter bit               GALOIS = MODE_GALOIS,
  parameter int unsigned      CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic [CNT_W-1:0] period_len,
  output logic             lockup_err
);

  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] start_r;
  logic             valid_r;
  logic             wrap_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] cnt_r;
  logic             lockup_r;

  logic [WIDTH-1:0] next_s;
  logic             step_s;
  logic [CNT_W-1:0] cnt_inc_s;

  lfsr_step #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .GALOIS (GALOIS)
  ) u_step (
    .state      (q_r),
    .next_state (next_s)
  );

  assign step_s    = en & valid_r & out_ready & ~seed_load;
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);

  // Generator state: load beats step; a zero state or zero seed falls back to SEED.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_r      <= SEED;
      start_r  <= SEED;
      valid_r  <= 1'b0;
      wrap_r   <= 1'b0;
      period_r <= CNT_ZERO;
      cnt_r    <= CNT_ZERO;
      lockup_r <= 1'b0;
    end else if (seed_load) begin
      valid_r <= 1'b0;
      wrap_r  <= 1'b0;
      cnt_r   <= CNT_ZERO;
      if (seed_in == W_ZERO) begin
        q_r      <= SEED;
        start_r  <= SEED;
        lockup_r <= 1'b1;
      end else begin
        q_r      <= seed_in;
        start_r  <= seed_in;
        lockup_r <= 1'b0;
      end
    end else begin
      valid_r <= 1'b1;
      if (step_s) begin
        if (q_r == W_ZERO) begin
          q_r      <= SEED;
          start_r  <= SEED;
          lockup_r <= 1'b1;
          wrap_r   <= 1'b0;
          cnt_r    <= CNT_ZERO;
        end else if (next_s == start_r) begin
          q_r      <= next_s;
          wrap_r   <= 1'b1;
          period_r <= cnt_inc_s;
          cnt_r    <= CNT_ZERO;
        end else begin
          q_r    <= next_s;
          wrap_r <= 1'b0;
          cnt_r  <= cnt_inc_s;
        end
      end else begin
        wrap_r <= 1'b0;
      end
    end
  end

  assign q          = q_r;
  assign out_valid  = valid_r;
  assign wrap       = wrap_r;
  assign period_len = period_r;
  assign lockup_err = lockup_r;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed bench for lfsr_prng_gen: Galois and Fibonacci instances share stimulus
// and are checked every cycle against a position-on-the-cycle model.
module tb_lfsr_prng_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        seed_load;
  logic [7:0]  seed_in;
  logic        out_ready;

  logic        out_valid_g, out_valid_f;
  logic [7:0]  q_g, q_f;
  logic        wrap_g, wrap_f;
  logic [31:0] period_g, period_f;
  logic        lockup_g, lockup_f;

  int n_checks = 0;
  int n_fail   = 0;

  lfsr_prng_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .GALOIS(1'b1), .CNT_W(32)) dut_g (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(out_valid_g), .q(q_g), .wrap(wrap_g),
    .period_len(period_g), .lockup_err(lockup_g)
  );

  lfsr_prng_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .GALOIS(1'b0), .CNT_W(32)) dut_f (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .out_ready(out_ready), .out_valid(out_valid_f), .q(q_f), .wrap(wrap_f),
    .period_len(period_f), .lockup_err(lockup_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] ref_galois(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  function automatic logic [7:0] ref_fib(input logic [7:0] x);
    return {x[6:0], ^(x & 8'hB8)};
  endfunction

  // The whole 255-state orbit of each structure, and each value's position on it.
  logic [7:0] tbl_g [0:254];
  logic [7:0] tbl_f [0:254];
  int         idx_g [0:255];
  int         idx_f [0:255];

  // Model: positions on the orbit plus handshake/flag state.
  bit model_on = 1'b0;
  int pg, pf, sg, sf, per_g, per_f;
  bit m_valid, m_wrap_g, m_wrap_f, m_lock;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      model_on = 1'b1;
      pg = 0; pf = 0; sg = 0; sf = 0; per_g = 0; per_f = 0;
      m_valid = 1'b0; m_wrap_g = 1'b0; m_wrap_f = 1'b0; m_lock = 1'b0;
    end else if (model_on) begin
      if (seed_load) begin
        if (seed_in == 8'h00) begin
          pg = 0; pf = 0; m_lock = 1'b1;
        end else begin
          pg = idx_g[seed_in]; pf = idx_f[seed_in]; m_lock = 1'b0;
        end
        sg = pg; sf = pf;
        m_valid = 1'b0; m_wrap_g = 1'b0; m_wrap_f = 1'b0;
      end else begin
        if (en && m_valid && out_ready) begin
          pg = (pg + 1) % 255;
          pf = (pf + 1) % 255;
          m_wrap_g = (pg == sg);
          m_wrap_f = (pf == sf);
          if (m_wrap_g) per_g = 255;
          if (m_wrap_f) per_f = 255;
        end else begin
          m_wrap_g = 1'b0; m_wrap_f = 1'b0;
        end
        m_valid = 1'b1;
      end
    end
    #1;
    if (model_on) begin
      check("model_q_g", q_g, tbl_g[pg]);
      check("model_q_f", q_f, tbl_f[pf]);
      check("model_valid_g", out_valid_g, m_valid);
      check("model_valid_f", out_valid_f, m_valid);
      check("model_wrap_g", wrap_g, m_wrap_g);
      check("model_wrap_f", wrap_f, m_wrap_f);
      check("model_period_g", period_g, per_g);
      check("model_period_f", period_f, per_f);
      check("model_lockup_g", lockup_g, m_lock);
      check("model_lockup_f", lockup_f, m_lock);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] exp_g [0:5];
  logic [7:0] exp_f [0:4];
  bit         seen [0:255];
  int         wraps;
  logic [7:0] held;
  logic [7:0] x;

  initial begin
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin tbl_g[i] = x; idx_g[x] = i; x = ref_galois(x); end
    x = 8'h01;
    for (int i = 0; i < 255; i++) begin tbl_f[i] = x; idx_f[x] = i; x = ref_fib(x); end
    exp_g = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
    exp_f = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed_in = 8'h00; out_ready = 1'b0;
    tick(); tick();
    check("reset_q", q_g, 8'h01);
    check("reset_valid", out_valid_g, 1'b0);
    check("reset_period", period_g, 32'd0);
    check("reset_lockup", lockup_g, 1'b0);

    // Galois and Fibonacci sequences, full Fibonacci period.
    rst_n = 1'b1; en = 1'b1; out_ready = 1'b1;
    tick();
    check("valid_after_release", out_valid_g, 1'b1);
    check("first_word", q_g, 8'h01);
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    seen[q_f] = 1'b1;
    wraps = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (k <= 5) check("galois_seq", q_g, exp_g[k]);
      if (k <= 4) check("fib_seq", q_f, exp_f[k]);
      if (wrap_f) wraps++;
      if (k < 255) begin
        check("fib_unique", seen[q_f], 1'b0);
        seen[q_f] = 1'b1;
      end
    end
    check("fib_wrap_count", wraps, 32'd1);
    check("fib_period", period_f, 32'd255);
    check("fib_back_to_seed", q_f, 8'h01);
    check("galois_wrap", wrap_g, 1'b1);
    check("galois_period", period_g, 32'd255);

    // Backpressure, then repeat-word mode.
    tick(); tick(); tick();
    held = q_g;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_q", q_g, held);
      check("stall_valid", out_valid_g, 1'b1);
    end
    out_ready = 1'b1;
    tick();
    check("resume_next", q_g, ref_galois(held));
    held = q_g;
    en = 1'b0;
    tick(); tick();
    check("repeat_word", q_g, held);
    en = 1'b1;

    // Seed load beats a simultaneous accept, then a full period from 0x5A.
    seed_load = 1'b1; seed_in = 8'h5A;
    tick();
    seed_load = 1'b0;
    check("load_q_g", q_g, 8'h5A);
    check("load_q_f", q_f, 8'h5A);
    check("load_valid_low", out_valid_g, 1'b0);
    tick();
    check("load_valid_back", out_valid_g, 1'b1);
    check("load_q_hold", q_g, 8'h5A);
    wraps = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (wrap_g) wraps++;
    end
    check("seed_wrap_count", wraps, 32'd1);
    check("seed_wrap_now", wrap_g, 1'b1);
    check("seed_period", period_g, 32'd255);
    check("seed_back", q_g, 8'h5A);

    // Zero seed falls back to SEED and latches the error until a good seed.
    seed_load = 1'b1; seed_in = 8'h00;
    tick();
    seed_load = 1'b0;
    check("zero_seed_q", q_g, 8'h01);
    check("zero_seed_lock", lockup_g, 1'b1);
    check("zero_seed_lock_f", lockup_f, 1'b1);
    tick(); tick(); tick();
    check("lock_sticky", lockup_g, 1'b1);
    seed_load = 1'b1; seed_in = 8'h33;
    tick();
    seed_load = 1'b0;
    check("lock_cleared", lockup_g, 1'b0);
    check("reload_q", q_g, 8'h33);

    // Reset mid-operation restarts the first sequence.
    for (int k = 0; k < 101; k++) tick();
    rst_n = 1'b0;
    tick();
    check("midreset_q", q_g, 8'h01);
    check("midreset_valid", out_valid_g, 1'b0);
    check("midreset_period", period_g, 32'd0);
    rst_n = 1'b1;
    tick();
    check("restart_valid", out_valid_g, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("restart_galois", q_g, exp_g[k]);
      if (k <= 4) check("restart_fib", q_f, exp_f[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
